// File: rtl/cb_burst_agd.sv
// Burst address generator for the banked, group-packed symmetric covariance buffer.
// Latency: element 0 reaches the outputs 4 cycles after request acceptance, then one per cycle.
// Backpressure: out_valid & ~out_ready freezes the burst counters and every pipeline stage.
module cb_burst_agd #(
    parameter int ROW_LEN = 10,
    parameter int GW      = 3,
    parameter int CB_AW   = 17,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ROW_LEN-1:0] req_row,
    input  logic [ROW_LEN-1:0] req_col,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               req_fold,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CB_AW-1:0]   out_addr,
    output logic [GW-1:0]      out_bank,
    output logic               out_swapped,
    output logic               out_err,
    output logic               out_last,
    output logic               busy
);

    localparam int KW = ROW_LEN - GW;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [ROW_LEN-1:0] COL_ONE = 1;
    localparam logic [LEN_W-1:0]   LEN_ONE = 1;
    localparam logic [2*KW-1:0]    K_ONE   = 1;

    logic [0:0]         state;
    logic [ROW_LEN-1:0] b_row;
    logic [ROW_LEN-1:0] b_col;
    logic [LEN_W-1:0]   b_rem;
    logic               b_fold;

    logic stall;
    logic push;

    assign stall = out_valid & ~out_ready;
    assign push  = (state == ST_BURST) & ~stall;

    // S0: issue
    logic               s0_vld;
    logic [ROW_LEN-1:0] s0_row;
    logic [ROW_LEN-1:0] s0_col;
    logic               s0_fold;
    logic               s0_last;

    // S1: folded coordinates split into group/lane
    logic               s1_vld;
    logic [KW-1:0]      s1_k;
    logic [GW-1:0]      s1_i;
    logic [ROW_LEN-1:0] s1_col;
    logic               s1_swp;
    logic               s1_err;
    logic               s1_last;

    // S2: triangular group base
    logic               s2_vld;
    logic [2*KW-1:0]    s2_tri;
    logic [GW-1:0]      s2_i;
    logic [ROW_LEN-1:0] s2_col;
    logic               s2_swp;
    logic               s2_err;
    logic               s2_last;

    assign req_ready = (state == ST_IDLE) & ~sys_rst;
    assign busy      = (state != ST_IDLE) | s0_vld | s1_vld | s2_vld | out_valid;

    // Burst FSM: latch a request, then walk the columns one per unstalled cycle
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state  <= ST_IDLE;
            b_row  <= '0;
            b_col  <= '0;
            b_rem  <= '0;
            b_fold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // zero-length requests are consumed here and never reach the pipeline
                    if (req_valid && (req_len != '0)) begin
                        b_row  <= req_row;
                        b_col  <= req_col;
                        b_rem  <= req_len;
                        b_fold <= req_fold;
                        state  <= ST_BURST;
                    end
                end
                default: begin
                    if (!stall) begin
                        b_col <= b_col + COL_ONE;
                        b_rem <= b_rem - LEN_ONE;
                        if (b_rem == LEN_ONE) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // S0 capture: a bubble is inserted whenever the FSM is not pushing
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            s0_vld  <= 1'b0;
            s0_row  <= '0;
            s0_col  <= '0;
            s0_fold <= 1'b0;
            s0_last <= 1'b0;
        end else if (!stall) begin
            s0_vld  <= push;
            s0_row  <= b_row;
            s0_col  <= b_col;
            s0_fold <= b_fold;
            s0_last <= (b_rem == LEN_ONE);
        end
    end

    // Fold decision: an element above the stored block triangle is either mirrored or flagged
    logic               upper;
    logic               do_swap;
    logic [ROW_LEN-1:0] eff_row;
    logic [ROW_LEN-1:0] eff_col;

    always_comb begin
        upper   = s0_col[ROW_LEN-1:GW] > s0_row[ROW_LEN-1:GW];
        do_swap = upper & s0_fold;
        eff_row = do_swap ? s0_col : s0_row;
        eff_col = do_swap ? s0_row : s0_col;
    end

    // S1 register: group index, bank lane and the unshifted column
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            s1_vld  <= 1'b0;
            s1_k    <= '0;
            s1_i    <= '0;
            s1_col  <= '0;
            s1_swp  <= 1'b0;
            s1_err  <= 1'b0;
            s1_last <= 1'b0;
        end else if (!stall) begin
            s1_vld  <= s0_vld;
            s1_k    <= eff_row[ROW_LEN-1:GW];
            s1_i    <= eff_row[GW-1:0];
            s1_col  <= eff_col;
            s1_swp  <= do_swap;
            s1_err  <= upper & ~s0_fold;
            s1_last <= s0_last;
        end
    end

    // k*(k+1) at full width; it is always even so halving is exact
    logic [2*KW-1:0] k_ext;
    logic [2*KW-1:0] prod;

    always_comb begin
        k_ext = {{KW{1'b0}}, s1_k};
        prod  = k_ext * (k_ext + K_ONE);
    end

    // S2 register: triangular number of complete groups preceding row group k
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            s2_vld  <= 1'b0;
            s2_tri  <= '0;
            s2_i    <= '0;
            s2_col  <= '0;
            s2_swp  <= 1'b0;
            s2_err  <= 1'b0;
            s2_last <= 1'b0;
        end else if (!stall) begin
            s2_vld  <= s1_vld;
            s2_tri  <= prod >> 1;
            s2_i    <= s1_i;
            s2_col  <= s1_col;
            s2_swp  <= s1_swp;
            s2_err  <= s1_err;
            s2_last <= s1_last;
        end
    end

    // Final address: each stored group occupies G words per bank, then offset by column
    logic [CB_AW-1:0] addr_c;

    always_comb begin
        addr_c = CB_AW'({s2_tri, {GW{1'b0}}}) + CB_AW'(s2_col);
    end

    // S3 output register: held while the consumer stalls
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_bank    <= '0;
            out_swapped <= 1'b0;
            out_err     <= 1'b0;
            out_last    <= 1'b0;
        end else if (!stall) begin
            out_valid   <= s2_vld;
            out_addr    <= addr_c;
            out_bank    <= s2_i;
            out_swapped <= s2_swp;
            out_err     <= s2_err;
            out_last    <= s2_last;
        end
    end

endmodule

// File: tb/tb_cb_burst_agd.sv
// Directed bench for cb_burst_agd: table of single-element requests plus
// hand-written burst, back-pressure/wrap, zero-length and mid-burst reset sequences.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cb_burst_agd;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_row;
    logic [9:0]  req_col;
    logic [9:0]  req_len;
    logic        req_fold;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_addr;
    logic [2:0]  out_bank;
    logic        out_swapped;
    logic        out_err;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    cb_burst_agd #(
        .ROW_LEN(10),
        .GW     (3),
        .CB_AW  (17),
        .LEN_W  (10)
    ) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_len    (req_len),
        .req_fold   (req_fold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_bank   (out_bank),
        .out_swapped(out_swapped),
        .out_err    (out_err),
        .out_last   (out_last),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nbad = 0;
    int acc_cyc = 0;
    int out_cyc = 0;

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic        fold;
        logic [16:0] addr;
        logic [2:0]  bank;
        logic        swp;
        logic        err;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [9:0] r, input logic [9:0] c, input logic [9:0] len, input logic f);
        int t = 0;
        req_row   = r;
        req_col   = c;
        req_len   = len;
        req_fold  = f;
        req_valid = 1'b1;
        while (!req_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            nvec++;
            nbad++;
            $display("FAIL send_timeout: req_ready low for %0d cycles, expected high", t);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    // Called at a falling edge; waits for the next transfer, checks it, returns at the falling edge after it.
    task automatic expect_out(input string nm, input logic [16:0] a, input logic [2:0] b,
                              input logic s, input logic e, input logic l);
        int t = 0;
        while (!(out_valid && out_ready) && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!(out_valid && out_ready)) begin
            nvec++;
            nbad++;
            $display("FAIL %s_timeout: out_valid=%0d, expected 1", nm, out_valid);
        end else begin
            out_cyc = cyc;
            chk({nm, "_addr"}, 32'(out_addr), 32'(a));
            chk({nm, "_bank"}, 32'(out_bank), 32'(b));
            chk({nm, "_swapped"}, 32'(out_swapped), 32'(s));
            chk({nm, "_err"}, 32'(out_err), 32'(e));
            chk({nm, "_last"}, 32'(out_last), 32'(l));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held;
        int extra;

        tbl[0] = '{row: 10'd5,    col: 10'd3,    fold: 1'b0, addr: 17'd3,     bank: 3'd5, swp: 1'b0, err: 1'b0};
        tbl[1] = '{row: 10'd12,   col: 10'd9,    fold: 1'b0, addr: 17'd17,    bank: 3'd4, swp: 1'b0, err: 1'b0};
        tbl[2] = '{row: 10'd1023, col: 10'd1023, fold: 1'b0, addr: 17'd66047, bank: 3'd7, swp: 1'b0, err: 1'b0};
        tbl[3] = '{row: 10'd3,    col: 10'd20,   fold: 1'b1, addr: 17'd27,    bank: 3'd4, swp: 1'b1, err: 1'b0};
        tbl[4] = '{row: 10'd3,    col: 10'd20,   fold: 1'b0, addr: 17'd20,    bank: 3'd3, swp: 1'b0, err: 1'b1};

        sys_rst   = 1'b1;
        req_valid = 1'b0;
        req_row   = '0;
        req_col   = '0;
        req_len   = '0;
        req_fold  = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        sys_rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // single-element requests
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].row, tbl[i].col, 10'd1, tbl[i].fold);
            expect_out($sformatf("vec%0d", i), tbl[i].addr, tbl[i].bank, tbl[i].swp, tbl[i].err, 1'b1);
            if (i == 0) chk("latency_first", 32'(out_cyc - acc_cyc), 32'd4);
        end

        // burst crossing the block diagonal with folding
        send(10'd12, 10'd14, 10'd4, 1'b1);
        expect_out("burst0", 17'd22, 3'd4, 1'b0, 1'b0, 1'b0);
        chk("burst_first_latency", 32'(out_cyc - acc_cyc), 32'd4);
        expect_out("burst1", 17'd23, 3'd4, 1'b0, 1'b0, 1'b0);
        expect_out("burst2", 17'd36, 3'd0, 1'b1, 1'b0, 1'b0);
        expect_out("burst3", 17'd36, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("burst_last_latency", 32'(out_cyc - acc_cyc), 32'd7);

        // back-pressure mid-burst with column wrap
        send(10'd1023, 10'd1022, 10'd3, 1'b0);
        expect_out("bp0", 17'd66046, 3'd7, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        held = 1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || out_addr != 17'd66047 || out_last) held = 0;
        end
        chk("bp_held", 32'(held), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        expect_out("bp1", 17'd66047, 3'd7, 1'b0, 1'b0, 1'b0);
        expect_out("bp2", 17'd65024, 3'd7, 1'b0, 1'b0, 1'b1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_no_extra", 32'(extra), 32'd0);

        // zero-length request is dropped
        req_row   = 10'd7;
        req_col   = 10'd1;
        req_len   = 10'd0;
        req_fold  = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("len0_ready", 32'(req_ready), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("len0_no_output", 32'(extra), 32'd0);

        // reset in the middle of a burst
        send(10'd5, 10'd0, 10'd8, 1'b0);
        expect_out("mr0", 17'd0, 3'd5, 1'b0, 1'b0, 1'b0);
        expect_out("mr1", 17'd1, 3'd5, 1'b0, 1'b0, 1'b0);
        expect_out("mr2", 17'd2, 3'd5, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        send(10'd12, 10'd9, 10'd1, 1'b0);
        expect_out("post_rst", 17'd17, 3'd4, 1'b0, 1'b0, 1'b1);
        chk("post_rst_latency", 32'(out_cyc - acc_cyc), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
